// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: response owner and priority state.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef enum logic {
        ST_PIPE_PRI = 1'b0,
        ST_DMA_PRI  = 1'b1
    } arb_state_e;

    // Wide enough for STARVE_LIMIT and BURST_MAX up to 255.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Pipeline, DMA and memory-port signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned WORD_SIZE = 32
) ();

    logic                 pipe_req;
    logic                 pipe_we;
    logic [ADDR_SIZE-1:0] pipe_addr;
    logic [WORD_SIZE-1:0] pipe_wdata;
    logic                 pipe_stall;
    logic [WORD_SIZE-1:0] pipe_rdata;

    logic                 dma_valid;
    logic                 dma_ready;
    logic                 dma_we;
    logic [ADDR_SIZE-1:0] dma_addr;
    logic [WORD_SIZE-1:0] dma_wdata;
    logic                 dma_rvalid;
    logic [WORD_SIZE-1:0] dma_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output pipe_stall, pipe_rdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester/memory side
    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  pipe_stall, pipe_rdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_ctrl.sv
// Priority FSM with starvation and burst counters; issues at most one grant per cycle.
module dmem_arb_ctrl
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned BURST_MAX    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pipe_req,
    input  logic dma_valid,
    output logic pipe_grant,
    output logic dma_grant
);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PIPE_PRI;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        burst_nxt  = burst_cnt;
        pipe_grant = 1'b0;
        dma_grant  = 1'b0;

        if (!rst) begin
            case (state)
                ST_PIPE_PRI: begin
                    if (pipe_req)       pipe_grant = 1'b1;
                    else if (dma_valid) dma_grant  = 1'b1;
                end
                ST_DMA_PRI: begin
                    if (dma_valid)      dma_grant  = 1'b1;
                    else if (pipe_req)  pipe_grant = 1'b1;
                end
                default: ;
            endcase
        end

        // A withdrawn DMA request counts as no longer starving.
        if (dma_grant || !dma_valid)
            starve_nxt = '0;
        else if (starve_cnt < CNT_W'(STARVE_LIMIT))
            starve_nxt = starve_cnt + CNT_W'(1);

        if (state == ST_DMA_PRI && dma_grant)
            burst_nxt = burst_cnt + CNT_W'(1);

        // Decide on the post-update counts so the switch takes effect the very next cycle.
        case (state)
            ST_PIPE_PRI: if (starve_nxt == CNT_W'(STARVE_LIMIT)) state_nxt = ST_DMA_PRI;
            ST_DMA_PRI:  if (burst_nxt == CNT_W'(BURST_MAX) || !dma_valid) state_nxt = ST_PIPE_PRI;
            default:     state_nxt = ST_PIPE_PRI;
        endcase

        if (state_nxt == ST_PIPE_PRI)
            burst_nxt = '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and the DMA/loader port.
// Define DMEM_ARB_STATS_EN to add stall and DMA-grant statistics counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_SIZE    = 10,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned BURST_MAX    = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]     stat_stall_cnt,
    output logic [31:0]     stat_dma_cnt,
`endif
    dmem_arbiter_if.slave   bus
);

    logic                 pipe_grant;
    logic                 dma_grant;
    logic                 we_sel;
    logic [ADDR_SIZE-1:0] addr_sel;
    logic [WORD_SIZE-1:0] wdata_sel;
    owner_e               rsp_owner, rsp_nxt;

    dmem_arb_ctrl #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .BURST_MAX    (BURST_MAX)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .pipe_req   (bus.pipe_req),
        .dma_valid  (bus.dma_valid),
        .pipe_grant (pipe_grant),
        .dma_grant  (dma_grant)
    );

    // Memory-port mux; idle port drives zeros.
    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        rsp_nxt   = OWN_NONE;
        if (pipe_grant) begin
            we_sel    = bus.pipe_we;
            addr_sel  = bus.pipe_addr;
            wdata_sel = bus.pipe_wdata;
            if (!bus.pipe_we) rsp_nxt = OWN_PIPE;
        end else if (dma_grant) begin
            we_sel    = bus.dma_we;
            addr_sel  = bus.dma_addr;
            wdata_sel = bus.dma_wdata;
            if (!bus.dma_we) rsp_nxt = OWN_DMA;
        end
    end

    assign bus.mem_en     = pipe_grant | dma_grant;
    assign bus.mem_we     = we_sel;
    assign bus.mem_addr   = addr_sel;
    assign bus.mem_wdata  = wdata_sel;
    assign bus.pipe_stall = bus.pipe_req & ~pipe_grant & ~rst;
    assign bus.dma_ready  = bus.dma_valid & dma_grant;
    assign bus.pipe_rdata = bus.mem_rdata;

    // Read data returns one cycle after the grant; DMA gets it re-registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_owner      <= OWN_NONE;
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= '0;
        end else begin
            rsp_owner      <= rsp_nxt;
            bus.dma_rvalid <= (rsp_owner == OWN_DMA);
            if (rsp_owner == OWN_DMA)
                bus.dma_rdata <= bus.mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_dma_cnt   <= '0;
        end else begin
            if (bus.pipe_stall) stat_stall_cnt <= stat_stall_cnt + 32'd1;
            if (dma_grant)      stat_dma_cnt   <= stat_dma_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a 1-cycle-latency memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_SIZE(10), .WORD_SIZE(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_stall_cnt;
    logic [31:0] stat_dma_cnt;
`endif

    dmem_arbiter #(
        .ADDR_SIZE    (10),
        .WORD_SIZE    (32),
        .STARVE_LIMIT (8),
        .BURST_MAX    (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
`ifdef DMEM_ARB_STATS_EN
        .stat_stall_cnt (stat_stall_cnt),
        .stat_dma_cnt   (stat_dma_cnt),
`endif
        .bus            (bus)
    );

    // Synchronous single-port memory, read-old-data on write.
    logic [31:0] mem [0:1023];
    logic [31:0] mem_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            mem_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_req   = 1'b0;
        bus.pipe_we    = 1'b0;
        bus.pipe_addr  = '0;
        bus.pipe_wdata = '0;
        bus.dma_valid  = 1'b0;
        bus.dma_we     = 1'b0;
        bus.dma_addr   = '0;
        bus.dma_wdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.pipe_req  = 1'b1;
        bus.dma_valid = 1'b1;
        bus.dma_we    = 1'b1;
        #2;
        vec_cnt++; if (bus.pipe_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_pipe_stall got %b want 0", bus.pipe_stall); end
        vec_cnt++; if (bus.dma_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_dma_ready got %b want 0", bus.dma_ready); end
        vec_cnt++; if (bus.mem_en !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
        vec_cnt++; if (bus.mem_we !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_dma_rvalid got %b want 0", bus.dma_rvalid); end
        vec_cnt++; if (bus.dma_rdata !== 32'h0) begin err_cnt++; $display("FAIL reset_dma_rdata got %h want 0", bus.dma_rdata); end
        cyc();
        rst = 1'b0;
        idle();
        #1;
        vec_cnt++; if (bus.mem_en !== 1'b0) begin err_cnt++; $display("FAIL idle_mem_en got %b want 0", bus.mem_en); end
    endtask

    task automatic test_pipe_load();
        // Preload address 5 through the DMA port.
        bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'd5; bus.dma_wdata = 32'hDEADBEEF;
        #1;
        vec_cnt++; if (bus.dma_ready !== 1'b1) begin err_cnt++; $display("FAIL preload_dma_ready got %b want 1", bus.dma_ready); end
        cyc();
        idle();
        bus.pipe_req = 1'b1; bus.pipe_we = 1'b0; bus.pipe_addr = 10'd5;
        #1;
        vec_cnt++; if (bus.pipe_stall !== 1'b0) begin err_cnt++; $display("FAIL pload_stall got %b want 0", bus.pipe_stall); end
        vec_cnt++; if (bus.mem_en !== 1'b1) begin err_cnt++; $display("FAIL pload_mem_en got %b want 1", bus.mem_en); end
        vec_cnt++; if (bus.mem_we !== 1'b0) begin err_cnt++; $display("FAIL pload_mem_we got %b want 0", bus.mem_we); end
        vec_cnt++; if (bus.mem_addr !== 10'd5) begin err_cnt++; $display("FAIL pload_mem_addr got %h want 005", bus.mem_addr); end
        cyc();
        idle();
        #1;
        vec_cnt++; if (bus.pipe_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL pload_rdata got %h want deadbeef", bus.pipe_rdata); end
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL pload_no_dma_rvalid got %b want 0", bus.dma_rvalid); end
    endtask

    task automatic test_dma_rw();
        bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'd3; bus.dma_wdata = 32'h12345678;
        #1;
        vec_cnt++; if (bus.dma_ready !== 1'b1) begin err_cnt++; $display("FAIL dwr_ready got %b want 1", bus.dma_ready); end
        vec_cnt++; if (bus.mem_we !== 1'b1) begin err_cnt++; $display("FAIL dwr_mem_we got %b want 1", bus.mem_we); end
        vec_cnt++; if (bus.mem_addr !== 10'd3) begin err_cnt++; $display("FAIL dwr_mem_addr got %h want 003", bus.mem_addr); end
        vec_cnt++; if (bus.mem_wdata !== 32'h12345678) begin err_cnt++; $display("FAIL dwr_mem_wdata got %h want 12345678", bus.mem_wdata); end
        cyc();
        bus.dma_we = 1'b0; bus.dma_wdata = '0;
        #1;
        vec_cnt++; if (bus.dma_ready !== 1'b1) begin err_cnt++; $display("FAIL drd_ready got %b want 1", bus.dma_ready); end
        vec_cnt++; if (bus.mem_we !== 1'b0) begin err_cnt++; $display("FAIL drd_mem_we got %b want 0", bus.mem_we); end
        cyc();
        idle();
        #1;
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL drd_rvalid_early got %b want 0", bus.dma_rvalid); end
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b1) begin err_cnt++; $display("FAIL drd_rvalid got %b want 1", bus.dma_rvalid); end
        vec_cnt++; if (bus.dma_rdata !== 32'h12345678) begin err_cnt++; $display("FAIL drd_rdata got %h want 12345678", bus.dma_rdata); end
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL drd_rvalid_drop got %b want 0", bus.dma_rvalid); end
    endtask

    task automatic test_contention();
        rst = 1'b1; #1; rst = 1'b0;
        bus.pipe_req = 1'b1; bus.pipe_we = 1'b0; bus.pipe_addr = 10'd5;
        bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'd7; bus.dma_wdata = 32'h000000AA;
        for (int i = 0; i < 24; i++) begin
            logic exp_stall;
            exp_stall = ((i % 12) >= 8);
            #1;
            vec_cnt++; if (bus.pipe_stall !== exp_stall) begin err_cnt++; $display("FAIL cont_stall[%0d] got %b want %b", i, bus.pipe_stall, exp_stall); end
            vec_cnt++; if (bus.dma_ready !== exp_stall) begin err_cnt++; $display("FAIL cont_dma_ready[%0d] got %b want %b", i, bus.dma_ready, exp_stall); end
            vec_cnt++; if (bus.mem_addr !== (exp_stall ? 10'd7 : 10'd5)) begin err_cnt++; $display("FAIL cont_mem_addr[%0d] got %h", i, bus.mem_addr); end
            cyc();
        end
`ifdef DMEM_ARB_STATS_EN
        vec_cnt++; if (stat_stall_cnt !== 32'd8) begin err_cnt++; $display("FAIL stat_stall_cnt got %0d want 8", stat_stall_cnt); end
        vec_cnt++; if (stat_dma_cnt !== 32'd8) begin err_cnt++; $display("FAIL stat_dma_cnt got %0d want 8", stat_dma_cnt); end
`endif
    endtask

    task automatic test_burst_abort();
        // Inputs still contending; FSM is back in pipeline priority with counters clear.
        for (int i = 0; i < 10; i++) begin
            logic exp_stall;
            exp_stall = (i >= 8);
            #1;
            vec_cnt++; if (bus.pipe_stall !== exp_stall) begin err_cnt++; $display("FAIL abort_pre_stall[%0d] got %b want %b", i, bus.pipe_stall, exp_stall); end
            cyc();
        end
        bus.dma_valid = 1'b0;
        #1;
        vec_cnt++; if (bus.pipe_stall !== 1'b0) begin err_cnt++; $display("FAIL abort_drop_stall got %b want 0", bus.pipe_stall); end
        vec_cnt++; if (bus.mem_addr !== 10'd5) begin err_cnt++; $display("FAIL abort_drop_addr got %h want 005", bus.mem_addr); end
        cyc();
        bus.dma_valid = 1'b1;
        // A full 4-grant burst afterwards shows burst_cnt was cleared.
        for (int j = 0; j < 12; j++) begin
            logic exp_stall;
            exp_stall = (j >= 8);
            #1;
            vec_cnt++; if (bus.pipe_stall !== exp_stall) begin err_cnt++; $display("FAIL abort_post_stall[%0d] got %b want %b", j, bus.pipe_stall, exp_stall); end
            vec_cnt++; if (bus.dma_ready !== exp_stall) begin err_cnt++; $display("FAIL abort_post_ready[%0d] got %b want %b", j, bus.dma_ready, exp_stall); end
            cyc();
        end
        idle();
    endtask

    task automatic test_reset_inflight();
        // Reset pulse between grant and data return discards the response.
        bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 10'd3;
        #1;
        vec_cnt++; if (bus.dma_ready !== 1'b1) begin err_cnt++; $display("FAIL rinf_ready got %b want 1", bus.dma_ready); end
        cyc();
        idle();
        rst = 1'b1; #1; rst = 1'b0;
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rinf_rvalid got %b want 0", bus.dma_rvalid); end
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rinf_rvalid_late got %b want 0", bus.dma_rvalid); end

        // Reset while read data is presented clears it immediately.
        bus.dma_valid = 1'b1;
        cyc();
        idle();
        cyc();
        vec_cnt++; if (bus.dma_rvalid !== 1'b1) begin err_cnt++; $display("FAIL rinf2_rvalid got %b want 1", bus.dma_rvalid); end
        rst = 1'b1; #1;
        vec_cnt++; if (bus.dma_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rinf2_async_rvalid got %b want 0", bus.dma_rvalid); end
        vec_cnt++; if (bus.dma_rdata !== 32'h0) begin err_cnt++; $display("FAIL rinf2_async_rdata got %h want 0", bus.dma_rdata); end
        rst = 1'b0;
        cyc();

        // Build up starvation, then reset: the full 8 pipeline grants must repeat.
        bus.pipe_req = 1'b1; bus.pipe_addr = 10'd5; bus.dma_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vec_cnt++; if (bus.pipe_stall !== 1'b0) begin err_cnt++; $display("FAIL rst_starve_pre[%0d] got %b want 0", i, bus.pipe_stall); end
            cyc();
        end
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic exp_stall;
            exp_stall = (i >= 8);
            #1;
            vec_cnt++; if (bus.pipe_stall !== exp_stall) begin err_cnt++; $display("FAIL rst_starve_post[%0d] got %b want %b", i, bus.pipe_stall, exp_stall); end
            cyc();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_pipe_load();
        test_dma_rw();
        test_contention();
        test_burst_abort();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
